// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - data memory req/ack bus between the M stage and memory
interface mem_access_stage_if #(
  parameter int ADDR_BITS = 12
);
  logic                 mem_req;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [31:0]          mem_wdata;
  logic                 mem_ack;
  logic [31:0]          mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - M stage: lw/sw over a req/ack memory bus, pass-through otherwise
// Optional BUS_TIMEOUT_EN: abandon WAIT after MAX_WAIT cycles and report a bus error.
module mem_access_stage #(
  parameter int ADDR_BITS = 12,
  parameter int MAX_WAIT  = 15
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [31:0]        in_o,
  input  logic [31:0]        in_b,
  input  logic [31:0]        in_ir,
  input  logic               in_ovf,
  mem_access_stage_if.master mem,
  output logic               stall,
  output logic [31:0]        out_o,
  output logic [31:0]        out_d,
  output logic [31:0]        out_ir,
  output logic               out_ovf
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [4:0] OP_LW = 5'b01000;
  localparam logic [4:0] OP_SW = 5'b00111;

  logic [1:0]           state;
  logic [ADDR_BITS-1:0] addr_q;
  logic [31:0]          wdata_q;
  logic [31:0]          ir_q;
  logic [31:0]          data_q;
  logic                 store_q;
  logic                 is_store;
  logic                 is_mem;
  logic                 timeout;
  logic                 err_q;

  assign is_store = (in_ir[31:27] == OP_SW);
  assign is_mem   = is_store || (in_ir[31:27] == OP_LW);

`ifdef BUS_TIMEOUT_EN
  localparam int CW = ($clog2(MAX_WAIT + 1) < 4) ? 4 : $clog2(MAX_WAIT + 1);

  logic [CW-1:0] wait_cnt;

  // Fires in the MAX_WAIT-th WAIT cycle; an ack in that same cycle still wins.
  assign timeout = (state == WAIT) && !mem.mem_ack && (wait_cnt == CW'(MAX_WAIT - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else if (state == IDLE && is_mem) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else if (state == WAIT && !mem.mem_ack) begin
      wait_cnt <= wait_cnt + 1'b1;
      err_q    <= timeout;
    end
  end
`else
  assign timeout = 1'b0;
  assign err_q   = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      ir_q    <= '0;
      data_q  <= '0;
      store_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (is_mem) begin
            addr_q  <= in_o[ADDR_BITS-1:0];
            wdata_q <= in_b;
            ir_q    <= in_ir;
            store_q <= is_store;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (mem.mem_ack) begin
            data_q <= store_q ? 32'd0 : mem.mem_rdata;
            state  <= DONE;
          end else if (timeout) begin
            data_q <= 32'd0;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem.mem_req   = (state == WAIT);
  assign mem.mem_we    = store_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  // Default outputs form the nop bubble seen by the M/W latch while stalled.
  always_comb begin
    stall   = 1'b0;
    out_o   = 32'd0;
    out_d   = 32'd0;
    out_ir  = 32'd0;
    out_ovf = 1'b0;
    case (state)
      IDLE: begin
        if (is_mem) begin
          stall = 1'b1;
        end else begin
          out_o   = in_o;
          out_ir  = in_ir;
          out_ovf = in_ovf;
        end
      end
      WAIT: stall = 1'b1;
      DONE: begin
        out_o[ADDR_BITS-1:0] = addr_q;
        out_d   = data_q;
        out_ir  = ir_q;
        out_ovf = err_q;
      end
      default: stall = 1'b0;
    endcase
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - randomized bench for mem_access_stage with a per-cycle expectation queue
module tb_mem_access_stage;
  localparam int AB = 12;
  localparam int MW = 15;
  localparam logic [4:0] LW = 5'b01000;
  localparam logic [4:0] SW = 5'b00111;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] in_o, in_b, in_ir;
  logic        in_ovf;
  logic        stall;
  logic [31:0] out_o, out_d, out_ir;
  logic        out_ovf;

  mem_access_stage_if #(.ADDR_BITS(AB)) bus ();

  mem_access_stage #(.ADDR_BITS(AB), .MAX_WAIT(MW)) dut (
    .clock   (clock),
    .reset   (reset),
    .in_o    (in_o),
    .in_b    (in_b),
    .in_ir   (in_ir),
    .in_ovf  (in_ovf),
    .mem     (bus),
    .stall   (stall),
    .out_o   (out_o),
    .out_d   (out_d),
    .out_ir  (out_ir),
    .out_ovf (out_ovf)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic          bus_chk;
    logic          data_chk;
    logic          stall;
    logic          req;
    logic          we;
    logic [AB-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   o;
    logic [31:0]   d;
    logic [31:0]   ir;
    logic          ovf;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   stall_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t blank();
    exp_t r;
    r.bus_chk = 0; r.data_chk = 0; r.stall = 0; r.req = 0; r.we = 0;
    r.addr = '0; r.wdata = '0; r.o = '0; r.d = '0; r.ir = '0; r.ovf = 0;
    return r;
  endfunction

  // One expectation record per driven cycle, consumed at the following falling edge.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("stall", stall, e.stall);
      chk("mem_req", bus.mem_req, e.req);
      chk("out_ir", out_ir, e.ir);
      chk("out_ovf", out_ovf, e.ovf);
      if (e.bus_chk) begin
        chk("mem_we", bus.mem_we, e.we);
        chk("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
        chk("mem_wdata", bus.mem_wdata, e.wdata);
      end
      if (e.data_chk) begin
        chk("out_o", out_o, e.o);
        chk("out_d", out_d, e.d);
      end
    end
    if (stall === 1'b1) stall_seen++;
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic run_nonmem(input logic [31:0] ir, input logic [31:0] o, input logic ovf);
    exp_t r;
    cyc();
    in_ir = ir; in_o = o; in_b = $urandom; in_ovf = ovf;
    bus.mem_ack = ($urandom_range(0, 2) == 0);
    bus.mem_rdata = $urandom;
    r = blank();
    r.data_chk = 1; r.o = o; r.d = 32'd0; r.ir = ir; r.ovf = ovf;
    exp_q.push_back(r);
  endtask

  // d = WAIT cycle (1-based) carrying the ack; 0 means the ack never comes.
  task automatic run_mem(input logic store, input logic [31:0] o, input logic [31:0] b,
                         input logic ovf, input int d, input logic [31:0] rdata);
    exp_t        r;
    logic [31:0] ir;
    int          waits;
    logic        timed_out;
    ir = {store ? SW : LW, 27'($urandom)};
    waits = d;
    timed_out = 1'b0;
`ifdef BUS_TIMEOUT_EN
    if (d == 0 || d > MW) begin
      waits = MW;
      timed_out = 1'b1;
    end
`endif
    cyc();
    in_ir = ir; in_o = o; in_b = b; in_ovf = ovf;
    bus.mem_ack = $urandom_range(0, 1);
    bus.mem_rdata = $urandom;
    r = blank();
    r.stall = 1;
    exp_q.push_back(r);
    for (int k = 1; k <= waits; k++) begin
      cyc();
      bus.mem_ack = !timed_out && (k == d);
      bus.mem_rdata = (k == d) ? rdata : $urandom;
      r = blank();
      r.stall = 1; r.req = 1; r.bus_chk = 1;
      r.we = store; r.addr = o[AB-1:0]; r.wdata = b;
      exp_q.push_back(r);
    end
    cyc();
    bus.mem_ack = $urandom_range(0, 1);
    bus.mem_rdata = $urandom;
    r = blank();
    r.data_chk = 1;
    r.o = 32'(o[AB-1:0]);
    r.d = (store || timed_out) ? 32'd0 : rdata;
    r.ir = ir;
    r.ovf = timed_out;
    exp_q.push_back(r);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rir;
    exp_t        r;
    reset = 1'b1;
    in_o = '0; in_b = '0; in_ir = '0; in_ovf = 1'b0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    repeat (3) @(posedge clock);
    @(negedge clock); #1;
    chk("reset mem_req", bus.mem_req, 1'b0);
    chk("reset mem_we", bus.mem_we, 1'b0);
    chk("reset mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("reset mem_wdata", bus.mem_wdata, 32'd0);
    chk("reset stall", stall, 1'b0);
    reset = 1'b0;

    // add passes straight through with its overflow flag
    run_nonmem({5'b00000, 27'h0}, 32'h0000_0005, 1'b1);
    @(negedge clock); #1;
    chk("add out_o", out_o, 32'h0000_0005);
    chk("add out_ovf", out_ovf, 1'b1);
    chk("add stall", stall, 1'b0);

    stall_seen = 0;
    run_mem(1'b0, 32'h0000_0A10, 32'h0, 1'b1, 2, 32'hDEAD_BEEF);
    @(negedge clock); #1;
    chk("lw out_d", out_d, 32'hDEAD_BEEF);
    chk("lw out_o", out_o, 32'h0000_0A10);
    chk("lw opcode", 32'(out_ir[31:27]), 32'(LW));
    chk("lw stall cycles", stall_seen, 3);

    stall_seen = 0;
    run_mem(1'b1, 32'h0000_0004, 32'h1234_5678, 1'b0, 1, 32'hFFFF_FFFF);
    @(negedge clock); #1;
    chk("sw out_d", out_d, 32'h0);
    chk("sw stall cycles", stall_seen, 2);

    // back-to-back lw then sw, then a non-memory op seeing a spurious ack
    run_mem(1'b0, 32'h0000_0123, 32'hAAAA_5555, 1'b0, 3, 32'h0BAD_F00D);
    run_mem(1'b1, 32'h0000_0FFC, 32'h5555_AAAA, 1'b1, 1, 32'h1111_1111);
    run_nonmem({5'b00011, 27'h1}, 32'hFFFF_FFFF, 1'b0);

    // reset in the middle of WAIT abandons the access
    cyc();
    in_ir = {LW, 27'h0}; in_o = 32'h0000_0321; in_b = 32'h0; in_ovf = 1'b0; bus.mem_ack = 1'b0;
    r = blank(); r.stall = 1; exp_q.push_back(r);
    cyc();
    r = blank(); r.stall = 1; r.req = 1; r.bus_chk = 1; r.addr = 12'h321; exp_q.push_back(r);
    cyc();
    reset = 1'b1;
    exp_q.push_back(r);
    cyc();
    reset = 1'b0;
    in_ir = {5'b00011, 27'h55}; in_o = 32'd77; in_ovf = 1'b0;
    r = blank(); r.data_chk = 1; r.o = 32'd77; r.ir = in_ir; exp_q.push_back(r);
    @(negedge clock); #1;
    chk("post-reset mem_req", bus.mem_req, 1'b0);
    chk("post-reset mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("post-reset stall", stall, 1'b0);

`ifdef BUS_TIMEOUT_EN
    stall_seen = 0;
    run_mem(1'b0, 32'h0000_0ABC, 32'h1, 1'b0, 0, 32'h0);
    @(negedge clock); #1;
    chk("timeout out_ovf", out_ovf, 1'b1);
    chk("timeout out_d", out_d, 32'h0);
    chk("timeout stall cycles", stall_seen, MW + 1);
    run_mem(1'b0, 32'h0000_0100, 32'h1, 1'b0, MW, 32'hCAFE_F00D);
    @(negedge clock); #1;
    chk("late ack out_ovf", out_ovf, 1'b0);
    chk("late ack out_d", out_d, 32'hCAFE_F00D);
`endif

    for (int n = 0; n < 120; n++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          rir = $urandom;
          while (rir[31:27] == LW || rir[31:27] == SW) rir = $urandom;
          run_nonmem(rir, $urandom, 1'($urandom));
        end
        default: begin
`ifdef BUS_TIMEOUT_EN
          run_mem(1'($urandom), $urandom, $urandom, 1'($urandom), $urandom_range(0, MW + 1), $urandom);
`else
          run_mem(1'($urandom), $urandom, $urandom, 1'($urandom), $urandom_range(1, 4), $urandom);
`endif
        end
      endcase
    end

    @(negedge clock); #1;
    chk("expectations drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory (M) stage of the 5-stage pipeline; sits between the X/M latch and the M/W latch.
- Decodes the instruction held in the X/M latch:
  - Loads and stores go to a variable-latency data memory over a req/ack handshake. The whole pipeline stalls until the access completes.
  - All other instructions pass straight through to the M/W latch in one cycle.

Parameters:
- ADDR_BITS, 12, number of low address bits driven on mem_addr.
- MAX_WAIT, 15, cycles in WAIT before a bus timeout (used only with BUS_TIMEOUT_EN).

Ports:
- clock  in  1  pipeline clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_o  in  32  ALU result / effective address from the X/M latch.
- in_b  in  32  store data (rt value) from the X/M latch.
- in_ir  in  32  instruction from the X/M latch.
- in_ovf  in  1  ALU overflow flag from the X/M latch.
- mem_req  out  1  memory request, held high until ack.
- mem_we  out  1  1 = store, 0 = load; valid while mem_req is high.
- mem_addr  out  ADDR_BITS  word address.
- mem_wdata  out  32  store data.
- mem_ack  in  1  memory completion, one-cycle pulse.
- mem_rdata  in  32  load data; valid in the cycle mem_ack is high.
- stall  out  1  freeze PC, F/D, D/X and X/M latches.
- out_o  out  32  to the M/W latch.
- out_d  out  32  to the M/W latch.
- out_ir  out  32  to the M/W latch.
- out_ovf  out  1  to the M/W latch.

Behaviour:
- Decode on in_ir[31:27]: 01000 = lw, 00111 = sw, anything else = non-memory.
- States: IDLE, WAIT, DONE. Reset forces IDLE and clears all internal registers; it overrides any other event on that edge.
- State after reset:
  - mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - In IDLE, stall and the out_* ports follow the IDLE rules below.
- IDLE with a non-memory instruction:
  - stall = 0.
  - out_o = in_o, out_d = 0, out_ir = in_ir, out_ovf = in_ovf (combinational pass-through).
  - Latency is one cycle, equal to a plain latch.
- IDLE with lw/sw:
  - stall = 1 combinationally.
  - out_ir = 0 and out_ovf = 0, so the M/W latch captures a nop bubble.
  - On the clock edge: capture in_o[ADDR_BITS-1:0], in_b, in_ir and the op type into registers; go to WAIT.
- WAIT:
  - mem_req = 1; mem_we, mem_addr and mem_wdata come from the captured registers and stay stable.
  - stall = 1; a bubble is presented to the M/W latch.
  - On mem_ack = 1: capture mem_rdata (loads only; stores capture 0) and go to DONE.
- DONE:
  - mem_req = 0, stall = 0.
  - out_o = captured address zero-extended to 32 bits, out_d = captured data, out_ir = captured ir, out_ovf = 0.
  - Next edge: the M/W latch takes the result, the upstream stages advance, and the FSM returns to IDLE.
  - Minimum lw/sw occupancy is 3 cycles (IDLE, WAIT, DONE) when ack arrives in the first WAIT cycle.
- mem_ack outside WAIT is ignored.
- Back-to-back memory ops: the instruction that arrives in the cycle after DONE re-enters IDLE decode normally; there is no dead cycle beyond the FSM itself.
- Reset while in WAIT: mem_req drops on the next edge and the access is abandoned. The memory model must tolerate a dropped req.
- in_ovf is not propagated for lw/sw.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - A 4-bit-minimum counter is cleared on entry to WAIT and increments each WAIT cycle without ack.
  - When the count reaches MAX_WAIT with no ack: go to DONE with out_d = 0 and out_ovf = 1 (bus error reported to writeback).
  - Ack in the same cycle as the limit wins, giving a normal completion.
- Not defined: no counter exists; WAIT lasts until mem_ack indefinitely.

Test Plan:
- add (in_ir opcode 00000, in_o = 0x0000_0005, in_ovf = 1), no stall -> same cycle out_o = 5, out_d = 0, out_ovf = 1, stall = 0; mem_req never rises.
- lw, in_o = 0x0000_0A10, ack after 2 WAIT cycles with rdata = 0xDEAD_BEEF -> mem_addr = 0xA10, mem_we = 0; stall high 3 cycles; DONE shows out_d = 0xDEAD_BEEF, out_ir = lw; bubble (out_ir = 0) in all stall cycles.
- sw, in_o = 0x0000_0004, in_b = 0x1234_5678, ack in first WAIT cycle -> mem_we = 1, mem_wdata = 0x1234_5678; stall is 1 for exactly 2 cycles; DONE shows out_d = 0.
- lw immediately followed by sw -> second request starts the cycle after DONE; addresses and data are not mixed; spurious mem_ack while in IDLE changes nothing.
- reset asserted during WAIT (no ack) -> next edge mem_req = 0, state IDLE, stall follows the new in_ir.
- BUS_TIMEOUT_EN, MAX_WAIT = 15, ack never comes -> after 15 WAIT cycles DONE shows out_ovf = 1, out_d = 0; repeat with ack on cycle 15 -> normal completion, out_ovf = 0.
